// File: rtl/dcache_port_arbiter.sv
// Single-port D-cache arbiter between the load queue and the store queue, with
// request locking, in-flight load tracking and store anti-starvation.
// Optional build macro: DCACHE_ARB_PERF_EN adds 32-bit wrapping performance counters.

package dcache_arb_pkg;
    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_command_t;

    typedef enum logic [1:0] {
        MEM_BYTE   = 2'd0,
        MEM_HALF   = 2'd1,
        MEM_WORD   = 2'd2,
        MEM_DOUBLE = 2'd3
    } mem_size_t;
endpackage

module dcache_port_arbiter
    import dcache_arb_pkg::*;
#(
    parameter int LQ_SIZE         = 16,
    parameter int LQ_IDX_WIDTH    = $clog2(LQ_SIZE),
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8,
    localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    ld_req_valid,
    input  logic [31:0]             ld_req_addr,
    input  mem_size_t               ld_req_size,
    input  logic [LQ_IDX_WIDTH-1:0] ld_req_tag,
    output logic                    ld_req_accept,

    input  logic                    st_req_valid,
    input  logic [31:0]             st_req_addr,
    input  mem_size_t               st_req_size,
    input  logic [63:0]             st_req_data,
    output logic                    st_req_accept,

    input  logic                    drain_i,
    input  logic                    squash_i,

    output logic [31:0]             dc_addr,
    output mem_command_t            dc_command,
    output mem_size_t               dc_size,
    output logic [63:0]             dc_store_data,
    output logic [LQ_IDX_WIDTH-1:0] dc_req_tag,
    input  logic                    dc_req_accept,
    input  logic                    dc_resp_valid,

`ifdef DCACHE_ARB_PERF_EN
    output logic [31:0]             perf_ld_grants,
    output logic [31:0]             perf_st_grants,
    output logic [31:0]             perf_conflict_cycles,
    output logic [31:0]             perf_starve_promotions,
`endif
    output logic [OUT_W-1:0]        outstanding_o
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [OUT_W-1:0]    MAX_OUT    = OUT_W'(MAX_OUTSTANDING);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_LOCK = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_LD   = 2'd1,
        SEL_ST   = 2'd2
    } sel_t;

    state_t              state;
    state_t              state_next;
    sel_t                sel;
    logic [STARVE_W-1:0] starve_cnt;
    logic [OUT_W-1:0]    outstanding;
    logic                ld_eligible;
    logic                st_promote;

    assign ld_eligible   = ld_req_valid && (outstanding < MAX_OUT);
    assign st_promote    = st_req_valid && (drain_i || (starve_cnt == STARVE_MAX));
    assign outstanding_o = outstanding;

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        sel           = SEL_NONE;
        state_next    = IDLE;
        dc_command    = MEM_NONE;
        dc_addr       = '0;
        dc_size       = MEM_BYTE;
        dc_store_data = '0;
        dc_req_tag    = '0;

        // A locked requester keeps the port until accepted, dropped or (loads) squashed.
        unique case (state)
            IDLE: begin
                if (st_promote)        sel = SEL_ST;
                else if (ld_eligible)  sel = SEL_LD;
                else if (st_req_valid) sel = SEL_ST;
            end
            LD_LOCK: if (!squash_i && ld_eligible) sel = SEL_LD;
            ST_LOCK: if (st_req_valid) sel = SEL_ST;
            default: sel = SEL_NONE;
        endcase

        if (!reset) sel = SEL_NONE;

        unique case (sel)
            SEL_LD: begin
                state_next = dc_req_accept ? IDLE : LD_LOCK;
                dc_command = MEM_LOAD;
                dc_addr    = ld_req_addr;
                dc_size    = ld_req_size;
                dc_req_tag = ld_req_tag;
            end
            SEL_ST: begin
                state_next    = dc_req_accept ? IDLE : ST_LOCK;
                dc_command    = MEM_STORE;
                dc_addr       = st_req_addr;
                dc_size       = st_req_size;
                dc_store_data = st_req_data;
            end
            default: state_next = IDLE;
        endcase
    end

    assign ld_req_accept = (sel == SEL_LD) && dc_req_accept;
    assign st_req_accept = (sel == SEL_ST) && dc_req_accept;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            outstanding <= '0;
        end else begin
            state <= state_next;

            if (!st_req_valid || st_req_accept)
                starve_cnt <= '0;
            else if ((sel != SEL_ST) && (starve_cnt != STARVE_MAX))
                starve_cnt <= starve_cnt + 1'b1;

            if (ld_req_accept && !dc_resp_valid)
                outstanding <= outstanding + 1'b1;
            else if (!ld_req_accept && dc_resp_valid && (outstanding != '0))
                outstanding <= outstanding - 1'b1;
        end
    end

`ifdef DCACHE_ARB_PERF_EN
    logic conflict;
    logic starve_win;

    assign conflict   = ld_req_valid && st_req_valid && (sel != SEL_NONE);
    // Counted only where the starvation rule actually overrode an eligible load.
    assign starve_win = (state == IDLE) && (sel == SEL_ST) && !drain_i &&
                        (starve_cnt == STARVE_MAX) && ld_eligible;

    always_ff @(posedge clock) begin
        if (!reset) begin
            perf_ld_grants         <= '0;
            perf_st_grants         <= '0;
            perf_conflict_cycles   <= '0;
            perf_starve_promotions <= '0;
        end else begin
            if (ld_req_accept) perf_ld_grants         <= perf_ld_grants + 32'd1;
            if (st_req_accept) perf_st_grants         <= perf_st_grants + 32'd1;
            if (conflict)      perf_conflict_cycles   <= perf_conflict_cycles + 32'd1;
            if (starve_win)    perf_starve_promotions <= perf_starve_promotions + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Self-checking bench for dcache_port_arbiter: reset, a directed vector table,
// multi-cycle corner sequences, then random traffic against a reference model.

module tb_dcache_port_arbiter;
    import dcache_arb_pkg::*;

    localparam int LIMIT   = 8;
    localparam int MAX_OUT = 4;
    localparam logic [31:0] LD_ADDR = 32'h0000_1000;
    localparam logic [31:0] ST_ADDR = 32'h0000_2000;
    localparam logic [63:0] ST_DATA = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [3:0]  LD_TAG  = 4'd5;

    logic         clock = 1'b0;
    logic         reset;
    logic         ld_req_valid;
    logic [31:0]  ld_req_addr;
    mem_size_t    ld_req_size;
    logic [3:0]   ld_req_tag;
    logic         ld_req_accept;
    logic         st_req_valid;
    logic [31:0]  st_req_addr;
    mem_size_t    st_req_size;
    logic [63:0]  st_req_data;
    logic         st_req_accept;
    logic         drain_i;
    logic         squash_i;
    logic [31:0]  dc_addr;
    mem_command_t dc_command;
    mem_size_t    dc_size;
    logic [63:0]  dc_store_data;
    logic [3:0]   dc_req_tag;
    logic         dc_req_accept;
    logic         dc_resp_valid;
    logic [2:0]   outstanding_o;

    int checks = 0;
    int errors = 0;

    // Reference model state: who holds the port (0 none, 1 load, 2 store), starvation age, loads in flight.
    int m_lock;
    int m_starve;
    int m_out;

    dcache_port_arbiter #(
        .LQ_SIZE(16), .MAX_OUTSTANDING(MAX_OUT), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clock(clock), .reset(reset),
        .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_req_size(ld_req_size),
        .ld_req_tag(ld_req_tag), .ld_req_accept(ld_req_accept),
        .st_req_valid(st_req_valid), .st_req_addr(st_req_addr), .st_req_size(st_req_size),
        .st_req_data(st_req_data), .st_req_accept(st_req_accept),
        .drain_i(drain_i), .squash_i(squash_i),
        .dc_addr(dc_addr), .dc_command(dc_command), .dc_size(dc_size),
        .dc_store_data(dc_store_data), .dc_req_tag(dc_req_tag),
        .dc_req_accept(dc_req_accept), .dc_resp_valid(dc_resp_valid),
        .outstanding_o(outstanding_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic         ld_v, st_v, drain, squash, acc, resp;
        mem_command_t cmd;
        logic         ld_acc, st_acc;
        int           outst;
    } vec_t;

    function automatic vec_t mk(input logic lv, sv, dr, sq, ac, rs,
                                input mem_command_t c, input logic la, sa, input int o);
        vec_t v;
        v.ld_v = lv; v.st_v = sv; v.drain = dr; v.squash = sq; v.acc = ac; v.resp = rs;
        v.cmd = c; v.ld_acc = la; v.st_acc = sa; v.outst = o;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic lv, sv, dr, sq, ac, rs);
        ld_req_valid  = lv;
        ld_req_addr   = LD_ADDR;
        ld_req_size   = MEM_WORD;
        ld_req_tag    = LD_TAG;
        st_req_valid  = sv;
        st_req_addr   = ST_ADDR;
        st_req_size   = MEM_DOUBLE;
        st_req_data   = ST_DATA;
        drain_i       = dr;
        squash_i      = sq;
        dc_req_accept = ac;
        dc_resp_valid = rs;
    endtask

    // Drive one cycle at the falling edge, compare 1 ns later, then move to the next falling edge.
    task automatic cyc(input string name, input logic lv, sv, dr, sq, ac, rs,
                       input mem_command_t c, input logic la, sa, input int o);
        drive(lv, sv, dr, sq, ac, rs);
        #1;
        check({name, ".cmd"}, 64'(dc_command), 64'(c));
        check({name, ".ld_acc"}, 64'(ld_req_accept), 64'(la));
        check({name, ".st_acc"}, 64'(st_req_accept), 64'(sa));
        check({name, ".outst"}, 64'(outstanding_o), 64'(o));
        if (c == MEM_LOAD) begin
            check({name, ".ld_addr"}, 64'(dc_addr), 64'(LD_ADDR));
            check({name, ".ld_tag"}, 64'(dc_req_tag), 64'(LD_TAG));
        end else if (c == MEM_STORE) begin
            check({name, ".st_addr"}, 64'(dc_addr), 64'(ST_ADDR));
            check({name, ".st_data"}, dc_store_data, ST_DATA);
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rst.cmd", 64'(dc_command), 64'(MEM_NONE));
            check("rst.ld_acc", 64'(ld_req_accept), 64'd0);
            check("rst.st_acc", 64'(st_req_accept), 64'd0);
            @(negedge clock);
        end
        check("rst.outst", 64'(outstanding_o), 64'd0);
        reset = 1'b1;
        m_lock = 0; m_starve = 0; m_out = 0;
    endtask

    function automatic int model_sel();
        bit ld_ok;
        ld_ok = ld_req_valid && (m_out < MAX_OUT);
        if (!reset)       return 0;
        if (m_lock == 1)  return (ld_ok && !squash_i) ? 1 : 0;
        if (m_lock == 2)  return st_req_valid ? 2 : 0;
        if (st_req_valid && (drain_i || m_starve == LIMIT)) return 2;
        if (ld_ok)        return 1;
        if (st_req_valid) return 2;
        return 0;
    endfunction

    task automatic model_commit(input int sel);
        bit la, sa;
        if (!reset) begin
            m_lock = 0; m_starve = 0; m_out = 0;
            return;
        end
        la = (sel == 1) && dc_req_accept;
        sa = (sel == 2) && dc_req_accept;
        m_lock = (sel != 0 && !dc_req_accept) ? sel : 0;
        if (!st_req_valid || sa)  m_starve = 0;
        else if (sel != 2)        m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
        if (la && !dc_resp_valid)               m_out = m_out + 1;
        else if (!la && dc_resp_valid && m_out > 0) m_out = m_out - 1;
    endtask

    vec_t tbl[16];

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clock);

        do_reset();

        // Priority, lock, drain, squash and valid-drop behaviour from a clean reset.
        tbl[0]  = mk(1,1,0,0,1,0, MEM_LOAD,  1,0, 0);
        tbl[1]  = mk(0,1,0,0,1,0, MEM_STORE, 0,1, 1);
        tbl[2]  = mk(0,0,0,0,0,1, MEM_NONE,  0,0, 1);
        tbl[3]  = mk(1,0,0,0,0,0, MEM_LOAD,  0,0, 0);
        tbl[4]  = mk(1,1,1,0,0,0, MEM_LOAD,  0,0, 0);
        tbl[5]  = mk(1,1,1,0,0,0, MEM_LOAD,  0,0, 0);
        tbl[6]  = mk(1,1,1,0,1,0, MEM_LOAD,  1,0, 0);
        tbl[7]  = mk(1,1,1,0,1,0, MEM_STORE, 0,1, 1);
        tbl[8]  = mk(0,1,0,0,0,0, MEM_STORE, 0,0, 1);
        tbl[9]  = mk(1,1,0,1,0,0, MEM_STORE, 0,0, 1);
        tbl[10] = mk(1,1,0,0,1,0, MEM_STORE, 0,1, 1);
        tbl[11] = mk(1,0,0,0,0,1, MEM_LOAD,  0,0, 1);
        tbl[12] = mk(1,1,0,1,1,0, MEM_NONE,  0,0, 0);
        tbl[13] = mk(1,1,0,0,0,0, MEM_LOAD,  0,0, 0);
        tbl[14] = mk(0,1,0,0,1,0, MEM_NONE,  0,0, 0);
        tbl[15] = mk(0,0,0,0,0,0, MEM_NONE,  0,0, 0);
        for (int i = 0; i < 16; i++)
            cyc($sformatf("vec%0d", i), tbl[i].ld_v, tbl[i].st_v, tbl[i].drain, tbl[i].squash,
                tbl[i].acc, tbl[i].resp, tbl[i].cmd, tbl[i].ld_acc, tbl[i].st_acc, tbl[i].outst);

        // Starvation: eight load wins, store promoted on the ninth, age cleared afterwards.
        do_reset();
        for (int i = 0; i < LIMIT; i++)
            cyc($sformatf("starve%0d", i), 1,1,0,0,1,1, MEM_LOAD, 1,0, 0);
        cyc("starve_promote", 1,1,0,0,1,1, MEM_STORE, 0,1, 0);
        cyc("starve_cleared", 1,1,0,0,1,1, MEM_LOAD, 1,0, 0);

        // Outstanding limit, then squash of a load lock leaves the count alone.
        do_reset();
        for (int i = 0; i < MAX_OUT; i++)
            cyc($sformatf("fill%0d", i), 1,0,0,0,1,0, MEM_LOAD, 1,0, i);
        cyc("full_store_wins", 1,1,0,0,1,0, MEM_STORE, 0,1, 4);
        cyc("full_no_load",    1,0,0,0,0,1, MEM_NONE,  0,0, 4);
        cyc("resp_load_again", 1,0,0,0,1,0, MEM_LOAD,  1,0, 3);
        cyc("refilled",        0,0,0,0,0,1, MEM_NONE,  0,0, 4);
        cyc("lock_load",       1,0,0,0,0,0, MEM_LOAD,  0,0, 3);
        cyc("squash_lock",     1,0,0,1,0,0, MEM_NONE,  0,0, 3);
        cyc("after_squash",    0,0,0,0,0,0, MEM_NONE,  0,0, 3);

        // Random traffic against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int           sel;
            mem_command_t exp_cmd;
            reset         = ($urandom_range(0, 63) != 0);
            ld_req_valid  = ($urandom_range(0, 3) != 0);
            ld_req_addr   = $urandom;
            ld_req_size   = mem_size_t'(2'($urandom_range(0, 3)));
            ld_req_tag    = 4'($urandom_range(0, 15));
            st_req_valid  = ($urandom_range(0, 2) != 0);
            st_req_addr   = $urandom;
            st_req_size   = mem_size_t'(2'($urandom_range(0, 3)));
            st_req_data   = {$urandom, $urandom};
            drain_i       = ($urandom_range(0, 7) == 0);
            squash_i      = ($urandom_range(0, 7) == 0);
            dc_req_accept = ($urandom_range(0, 1) != 0);
            dc_resp_valid = ($urandom_range(0, 2) == 0);
            #1;
            sel = model_sel();
            exp_cmd = (sel == 1) ? MEM_LOAD : (sel == 2) ? MEM_STORE : MEM_NONE;
            check("rnd.cmd", 64'(dc_command), 64'(exp_cmd));
            check("rnd.ld_acc", 64'(ld_req_accept), 64'((sel == 1) && dc_req_accept));
            check("rnd.st_acc", 64'(st_req_accept), 64'((sel == 2) && dc_req_accept));
            check("rnd.outst", 64'(outstanding_o), 64'(m_out));
            if (sel == 1)
                check("rnd.ld_payload", {dc_addr, 24'(dc_size), dc_req_tag, dc_store_data[3:0]},
                      {ld_req_addr, 24'(ld_req_size), ld_req_tag, 4'd0});
            else if (sel == 2)
                check("rnd.st_payload", {dc_store_data[31:0] ^ dc_addr, 28'(dc_size), dc_req_tag},
                      {st_req_data[31:0] ^ st_req_addr, 28'(st_req_size), 4'd0});
            model_commit(sel);
            @(negedge clock);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Shares one D-cache request port between the load queue (loads) and the store queue (committed stores).
- Enforces request/accept handshakes and tracks in-flight loads.
- Prevents store starvation with an aging counter and a drain override.
- Sits between lq/sq and the D-cache for configurations where the cache exposes a single request port instead of two.

Parameters:
- LQ_SIZE, 16, load queue depth; sets the tag width.
- LQ_IDX_WIDTH, $clog2(LQ_SIZE), load tag width.
- MAX_OUTSTANDING, 4, maximum loads accepted by the cache but not yet returned.
- STARVE_LIMIT, 8, consecutive cycles a pending store may lose arbitration before it is promoted.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- ld_req_valid  in  1  LQ load request
- ld_req_addr  in  32  load address (ADDR)
- ld_req_size  in  MEM_SIZE  load size
- ld_req_tag  in  LQ_IDX_WIDTH  LQ index of the load
- ld_req_accept  out  1  load taken by the cache this cycle
- st_req_valid  in  1  SQ committed-store request
- st_req_addr  in  32  store address
- st_req_size  in  MEM_SIZE  store size
- st_req_data  in  64  store data (MEM_BLOCK)
- st_req_accept  out  1  store taken by the cache this cycle
- drain_i  in  1  SQ near full; stores get priority
- squash_i  in  1  branch recovery; drops a pending load lock
- dc_addr  out  32  cache address
- dc_command  out  MEM_COMMAND  MEM_LOAD / MEM_STORE / MEM_NONE
- dc_size  out  MEM_SIZE  cache size
- dc_store_data  out  64  store data, '0 for loads
- dc_req_tag  out  LQ_IDX_WIDTH  load tag, '0 for stores
- dc_req_accept  in  1  cache accepted the current request
- dc_resp_valid  in  1  load data returned
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  in-flight load count

Behaviour:
- Reset (reset==0 at posedge):
  - state IDLE, starve_cnt 0, outstanding 0.
  - While reset is low, dc_command is MEM_NONE and both accepts are 0.
- Cache-side outputs are a combinational mux of the selected requester; request-to-cache latency is 0.
- Accept signals:
  - ld_req_accept = selected load AND dc_req_accept.
  - st_req_accept likewise for the selected store.
- Load eligibility: ld_req_valid AND outstanding < MAX_OUTSTANDING.
- States:
  - IDLE: no lock.
  - LD_LOCK: load presented, not yet accepted.
  - ST_LOCK: store presented, not yet accepted.
- Selection in IDLE, first match wins:
  1. Store, if st_req_valid AND (drain_i OR starve_cnt==STARVE_LIMIT).
  2. Eligible load.
  3. Store.
  4. Otherwise MEM_NONE.
- Lock entry and release:
  - Selected but not accepted: go to LD_LOCK / ST_LOCK. Next cycles present the same requester regardless of priority.
  - Accepted: return to IDLE. Back-to-back accepts in IDLE are allowed every cycle.
- Requester stability: a requester in lock must hold valid/addr/data stable. If valid drops while locked, return to IDLE and present MEM_NONE that cycle.
- Squash:
  - squash_i in LD_LOCK: go to IDLE, present MEM_NONE that cycle, no accept.
  - squash_i in ST_LOCK or IDLE: no effect, because committed stores are never squashed.
- starve_cnt:
  - Increments when st_req_valid and the store is not selected; saturates at STARVE_LIMIT.
  - Clears on st_req_accept or when st_req_valid is 0.
- outstanding:
  - +1 on ld_req_accept, -1 on dc_resp_valid; both in the same cycle leaves it unchanged.
  - dc_resp_valid at 0 saturates at 0.
  - squash_i does not change it; the LQ discards stale responses by tag.
- At outstanding==MAX_OUTSTANDING loads are ineligible. An existing LD_LOCK is released to IDLE, and a store may then win.

Optional Feature:
- DCACHE_ARB_PERF_EN defined: adds 32-bit output counters:
  - perf_ld_grants
  - perf_st_grants
  - perf_conflict_cycles (both valid, one loses)
  - perf_starve_promotions
  - All counters reset to 0, wrap at 2^32.
- Undefined: these ports and registers are absent; behaviour is otherwise identical.

Test Plan:
- Reset held low 3 cycles with both valids high -> dc_command MEM_NONE, both accepts 0, outstanding 0.
- Load and store valid, accept=1, drain 0, starve 0 -> load granted with dc_command MEM_LOAD and tag 5; next cycle (load valid dropped) store granted.
- Load and store valid continuously, accept=1, STARVE_LIMIT=8 -> store granted on the 9th cycle; starve_cnt back to 0.
- Load valid, dc_req_accept=0 for 3 cycles, store valid with drain_i=1 from cycle 2 -> load stays presented (LD_LOCK) until accept on cycle 4; store granted cycle 5.
- 4 loads accepted with no responses (MAX=4) -> 5th load not presented and store granted; one dc_resp_valid -> outstanding 3, load presented next cycle.
- LD_LOCK with squash_i=1 -> MEM_NONE that cycle, state IDLE, outstanding unchanged; a store in ST_LOCK with squash_i=1 remains presented.
